// File: rtl/ct_counter_n.sv
// N-bit loadable up/down counter with reload register, terminal hold and cascade carry.
// Optional build macro CT_SNAPSHOT_EN adds a SNAP strobe and QS snapshot register.
module ct_counter_n #(
   parameter int unsigned           WIDTH  = 8,
   parameter logic [WIDTH-1:0]      RVINIT = '0
) (
   input  logic             CK,
   input  logic             RESETL,
   input  logic [WIDTH-1:0] D,
   input  logic             LD,
   input  logic             LDR,
   input  logic             ENAB,
   input  logic             CI,
   input  logic             UP,
   input  logic             RELOAD,
   input  logic             HOLD,
`ifdef CT_SNAPSHOT_EN
   input  logic             SNAP,
   output logic [WIDTH-1:0] QS,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QL,
   output logic             CO,
   output logic             TCP
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] rv_r;
   logic             tcp_r;
   logic             ce;
   logic             term;

   // Terminal depends on direction, so a mid-count UP flip is seen immediately.
   always_comb begin
      ce   = ENAB & CI;
      term = UP ? (q_r == ALL_ONES) : (q_r == ZERO);
   end

   // Next-value priority: load, terminal hold, terminal reload, step, hold.
   always_comb begin
      q_nxt = q_r;
      if (LD) begin
         q_nxt = D;
      end else if (ce) begin
         if (term && HOLD) begin
            q_nxt = q_r;
         end else if (term && RELOAD) begin
            q_nxt = rv_r;
         end else if (UP) begin
            q_nxt = q_r + WIDTH'(1);
         end else begin
            q_nxt = q_r - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CK or negedge RESETL) begin
      if (!RESETL) begin
         q_r   <= ZERO;
         tcp_r <= 1'b0;
      end else begin
         q_r   <= q_nxt;
         tcp_r <= ce & term & ~LD;
      end
   end

   // Reload register; a same-edge reload still sees the previous value.
   always_ff @(posedge CK or negedge RESETL) begin
      if (!RESETL) begin
         rv_r <= RVINIT;
      end else if (LDR) begin
         rv_r <= D;
      end
   end

`ifdef CT_SNAPSHOT_EN
   logic [WIDTH-1:0] qs_r;

   // Captures the post-update value so software reads a coherent count.
   always_ff @(posedge CK or negedge RESETL) begin
      if (!RESETL) begin
         qs_r <= ZERO;
      end else if (SNAP) begin
         qs_r <= q_nxt;
      end
   end

   assign QS = qs_r;
`endif

   assign Q   = q_r;
   assign QL  = ~q_r;
   assign TCP = tcp_r;
   assign CO  = ce & term;

endmodule

// File: doc/ct_counter_n.md
Name: ct_counter_n

Overview:
- Parametrised N-bit synchronous loadable counter.
- Generalises the single-bit counter cell into a full register with up/down direction, a reload register, a stop-at-terminal mode and a cascade carry chain.
- Used by video/DMA timing blocks that need programmable dividers and line/pixel counters without hand-chaining bit cells.

Parameters:
- WIDTH, 8, counter/data width in bits (>=2).
- RVINIT, 0, reset value of the reload register (WIDTH bits).

Ports:
- CK  input  1  clock; all state changes on rising edge.
- RESETL  input  1  asynchronous active-low reset.
- D  input  WIDTH  parallel load data for counter and reload register.
- LD  input  1  load counter from D.
- LDR  input  1  load reload register RV from D.
- ENAB  input  1  local count enable.
- CI  input  1  cascade carry-in; tie high when not cascaded.
- UP  input  1  1 = count up, 0 = count down.
- RELOAD  input  1  1 = at terminal, next value is RV; 0 = natural wrap.
- HOLD  input  1  1 = counter sticks at terminal value (overrides RELOAD).
- Q  output  WIDTH  counter value.
- QL  output  WIDTH  bitwise inverse of Q.
- CO  output  1  combinational carry-out, = CI & ENAB & TERM.
- TCP  output  1  registered terminal pulse, high one cycle after a terminal step.

Behaviour:
- Reset: asynchronous on RESETL low.
  - Q=0, QL=all ones, RV=RVINIT, TCP=0.
  - CO follows its equation: with Q=0 and UP=0, CO=CI&ENAB.
- Reset release is synchronous in effect: the first update is on the first CK edge with RESETL high.
- TERM (internal, combinational): UP=1 -> Q==all ones; UP=0 -> Q==0.
- Count step: CE = ENAB & CI.
- Next-Q priority, per rising CK edge:
  1. LD=1 -> Q<=D. Loads ignore CE, HOLD, RELOAD.
  2. CE=1 & TERM & HOLD=1 -> Q unchanged.
  3. CE=1 & TERM & RELOAD=1 -> Q<=RV.
  4. CE=1 -> Q<=Q+1 (UP=1) or Q-1 (UP=0), modulo 2^WIDTH. Natural wrap: all ones->0 and 0->all ones.
  5. Otherwise Q holds.
- RV update: LDR=1 -> RV<=D, independent of LD.
  - LD and LDR together load both from the same D.
  - A reload in the same cycle as LDR uses the old RV. New RV is visible from the next edge.
- TCP<=CE & TERM & ~LD, evaluated at the edge. It pulses even when HOLD keeps Q at terminal, so it is high every cycle CE stays asserted in hold.
- UP changing mid-count takes effect on the next edge. TERM re-evaluates combinationally.
- Cascade: stage k CI = CO of stage k-1, all stages share CK. CO is purely combinational: no added latency and no registered path from CI to CO.
- Reset asserted mid-count aborts immediately. No pending load survives.

Optional Feature:
- Macro CT_SNAPSHOT_EN adds:
  - Input SNAP (1 bit).
  - Output QS (WIDTH bits).
- Behaviour with CT_SNAPSHOT_EN:
  - SNAP=1 at an edge -> QS<=value Q takes at that same edge (post-update value). Software reads a coherent value in the following cycle.
  - QS resets to 0.
  - SNAP has no effect on counting.
- Without the macro: SNAP/QS ports do not exist and there is no extra logic. Counter behaviour is identical in both builds.

Test Plan (WIDTH=4, RVINIT=0):
- Reset: hold RESETL low with ENAB=1 -> Q=0, QL=4'hF, TCP=0. Release, UP=1, CI=1, ENAB=1 for 17 edges -> Q runs 1..F,0,1. CO high only while Q=F. TCP high on the cycle after Q=F->0.
- Load priority: Q=5, LD=1, D=4'hA, ENAB=1, UP=1 -> Q=A (not 6). Next edge, LD=0 -> Q=B.
- Reload divider: LDR=1, D=4'h3. Then UP=1, RELOAD=1, count from D=4'hD -> Q sequence D,E,F,3,4... TCP pulses once per wrap. Same-cycle LDR with D=4'h7 at Q=F -> next Q=3, the following reload uses 7.
- Down/hold: UP=0, HOLD=1, load 2, count -> 1,0,0,0. CO=1 while Q=0 & CE. TCP high on every cycle CE stays asserted while Q=0. Drop HOLD, RELOAD=0 -> Q=F.
- Cascade: two instances (low CO->high CI), UP=1, start 8'h00 -> after 16 edges the pair reads 8'h10. After 255 edges it reads 8'hFF and the high-stage CO=1 in that cycle.
- CT_SNAPSHOT_EN: counting up from 0, SNAP=1 at edge 5 -> QS=5 while Q continues 6,7. Without the macro the build compiles and all other tests pass unchanged.
